writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_pkg.sv | 13 +
 rtl/wb_fifo.sv | 82 ++++++++
 rtl/writeback_arbiter.sv | 98 +++++++++
 tb/tb_writeback_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared constants and types for the writeback arbiter
package writeback_arbiter_pkg;

  localparam int ROB_INDEX_BIT_DEF = 4;
  localparam int WB_FIFO_DEPTH_DEF = 4;
  localparam int RESULT_W          = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source result FIFO with registered almost-full stall and drop pulse
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             stall,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             full;
  logic             accept;
  logic             do_push;
  logic             do_pop;

  assign accept    = rdy_in & ~clear;
  assign not_empty = (count != '0);
  assign full      = (count == (AW+1)'(DEPTH));
  assign head      = mem[rd_ptr];

  // A full FIFO still accepts a push when the same cycle pops it.
  assign do_pop  = accept & pop & not_empty;
  assign do_push = accept & push & (~full | do_pop);
  assign drop    = accept & push & full & ~do_pop;

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
    if (clear) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      stall  <= 1'b0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      stall  <= 1'b0;
    end else if (rdy_in) begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      stall <= (count_next >= (AW+1)'(DEPTH - 1));
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - round-robin merge of ALU and LSB results onto a registered CDB
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int WB_FIFO_DEPTH = WB_FIFO_DEPTH_DEF,
  parameter int ROB_INDEX_BIT = ROB_INDEX_BIT_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic                     alu_ready,
  input  logic [ROB_INDEX_BIT-1:0] alu_rob_id,
  input  logic [RESULT_W-1:0]      alu_result,
  input  logic                     lsb_ready,
  input  logic [ROB_INDEX_BIT-1:0] lsb_rob_id,
  input  logic [RESULT_W-1:0]      lsb_result,
  output logic                     alu_stall,
  output logic                     lsb_stall,
  output logic                     cdb_req,
  output logic [ROB_INDEX_BIT-1:0] cdb_rob_id,
  output logic [RESULT_W-1:0]      cdb_val,
  output logic                     overflow
);

  localparam int EW = ROB_INDEX_BIT + RESULT_W;

  logic [EW-1:0] alu_head;
  logic [EW-1:0] lsb_head;
  logic          alu_ne;
  logic          lsb_ne;
  logic          alu_drop;
  logic          lsb_drop;
  logic          grant_alu;
  logic          grant_lsb;
  wb_src_e       last_grant;

  wb_fifo #(.DEPTH(WB_FIFO_DEPTH), .WIDTH(EW)) u_alu_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .clear     (clear),
    .push      (alu_ready),
    .push_data ({alu_rob_id, alu_result}),
    .pop       (grant_alu),
    .head      (alu_head),
    .not_empty (alu_ne),
    .stall     (alu_stall),
    .drop      (alu_drop)
  );

  wb_fifo #(.DEPTH(WB_FIFO_DEPTH), .WIDTH(EW)) u_lsb_fifo (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .clear     (clear),
    .push      (lsb_ready),
    .push_data ({lsb_rob_id, lsb_result}),
    .pop       (grant_lsb),
    .head      (lsb_head),
    .not_empty (lsb_ne),
    .stall     (lsb_stall),
    .drop      (lsb_drop)
  );

  // On a tie the source that did not win last time goes first.
  always_comb begin
    grant_alu = alu_ne && (!lsb_ne || (last_grant == SRC_LSB));
    grant_lsb = lsb_ne && !grant_alu;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cdb_req    <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val    <= '0;
      overflow   <= 1'b0;
      last_grant <= SRC_LSB;
    end else begin
      if (alu_drop || lsb_drop) begin
        overflow <= 1'b1;
      end
      if (clear) begin
        cdb_req <= 1'b0;
      end else if (rdy_in) begin
        cdb_req <= grant_alu | grant_lsb;
        if (grant_alu) begin
          {cdb_rob_id, cdb_val} <= alu_head;
          last_grant            <= SRC_ALU;
        end else if (grant_lsb) begin
          {cdb_rob_id, cdb_val} <= lsb_head;
          last_grant            <= SRC_LSB;
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed-vector bench for writeback_arbiter
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int RB = ROB_INDEX_BIT_DEF;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          clear;
  logic          alu_ready;
  logic [RB-1:0] alu_rob_id;
  logic [31:0]   alu_result;
  logic          lsb_ready;
  logic [RB-1:0] lsb_rob_id;
  logic [31:0]   lsb_result;
  logic          alu_stall;
  logic          lsb_stall;
  logic          cdb_req;
  logic [RB-1:0] cdb_rob_id;
  logic [31:0]   cdb_val;
  logic          overflow;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  writeback_arbiter dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .clear      (clear),
    .alu_ready  (alu_ready),
    .alu_rob_id (alu_rob_id),
    .alu_result (alu_result),
    .lsb_ready  (lsb_ready),
    .lsb_rob_id (lsb_rob_id),
    .lsb_result (lsb_result),
    .alu_stall  (alu_stall),
    .lsb_stall  (lsb_stall),
    .cdb_req    (cdb_req),
    .cdb_rob_id (cdb_rob_id),
    .cdb_val    (cdb_val),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of source pulses, advance past the edge, then drop the pulses.
  task automatic tick(input logic av, input int aid, input int ad,
                      input logic lv, input int lid, input int ld);
    alu_ready  = av;
    alu_rob_id = RB'(aid);
    alu_result = 32'(ad);
    lsb_ready  = lv;
    lsb_rob_id = RB'(lid);
    lsb_result = 32'(ld);
    @(posedge clk_in);
    #1;
    alu_ready = 1'b0;
    lsb_ready = 1'b0;
  endtask

  task automatic idle();
    tick(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic expect_cdb(input string tag, input logic req, input int id, input int val);
    chk({tag, "_req"}, 64'(cdb_req), 64'(req));
    if (req) begin
      chk({tag, "_id"}, 64'(cdb_rob_id), 64'(id));
      chk({tag, "_val"}, 64'(cdb_val), 64'(val));
    end
  endtask

  int exp30_id [10] = '{-1, 8, 4, 9, 5, 10, 6, 11, 7, -1};
  int exp30_as [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  int exp31_id [17] = '{-1, 8, 0, 9, 1, 10, 2, 11, 3, 12, 4, 13, 5, 14, 6, 15, -1};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    alu_ready = 1'b0; alu_rob_id = '0; alu_result = '0;
    lsb_ready = 1'b0; lsb_rob_id = '0; lsb_result = '0;
    #2 rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_req", 64'(cdb_req), 64'd0);
    chk("rst_id", 64'(cdb_rob_id), 64'd0);
    chk("rst_val", 64'(cdb_val), 64'd0);
    chk("rst_astall", 64'(alu_stall), 64'd0);
    chk("rst_lstall", 64'(lsb_stall), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    rst_in = 1'b1;

    // Tie straight after reset: ALU first, then LSB.
    tick(1'b1, 1, 'hA, 1'b1, 2, 'hB); expect_cdb("tie1_e1", 1'b0, 0, 0);
    idle(); expect_cdb("tie1_e2", 1'b1, 1, 'hA);
    idle(); expect_cdb("tie1_e3", 1'b1, 2, 'hB);
    idle(); expect_cdb("tie1_e4", 1'b0, 0, 0);

    // Single ALU pulse shows for exactly one cycle after the push edge.
    tick(1'b1, 3, 'h11, 1'b0, 0, 0); expect_cdb("single_e1", 1'b0, 0, 0);
    idle(); expect_cdb("single_e2", 1'b1, 3, 'h11);
    idle(); expect_cdb("single_e3", 1'b0, 0, 0);

    // ALU won last, so the next tie goes to LSB first.
    tick(1'b1, 1, 'hA, 1'b1, 2, 'hB); expect_cdb("tie2_e1", 1'b0, 0, 0);
    idle(); expect_cdb("tie2_e2", 1'b1, 2, 'hB);
    idle(); expect_cdb("tie2_e3", 1'b1, 1, 'hA);
    idle(); expect_cdb("tie2_e4", 1'b0, 0, 0);

    // Four back-to-back pushes from both sources, alternating drain.
    for (int e = 0; e < 10; e++) begin
      if (e < 4) tick(1'b1, 4 + e, 'hA0 + e, 1'b1, 8 + e, 'hB0 + e);
      else idle();
      if (exp30_id[e] < 0) expect_cdb($sformatf("burst_e%0d", e + 1), 1'b0, 0, 0);
      else expect_cdb($sformatf("burst_e%0d", e + 1), 1'b1, exp30_id[e],
                      (exp30_id[e] < 8) ? 'hA0 + exp30_id[e] - 4 : 'hB0 + exp30_id[e] - 8);
      chk($sformatf("burst_astall_e%0d", e + 1), 64'(alu_stall), 64'(exp30_as[e]));
      chk($sformatf("burst_lstall_e%0d", e + 1), 64'(lsb_stall), 64'd0);
    end
    chk("burst_ovf", 64'(overflow), 64'd0);

    // Eight pushes each: the ALU FIFO fills and the eighth ALU entry is dropped.
    for (int e = 0; e < 17; e++) begin
      if (e < 8) tick(1'b1, e, 'h100 + e, 1'b1, 8 + e, 'h200 + 8 + e);
      else idle();
      if (exp31_id[e] < 0) expect_cdb($sformatf("ovf_e%0d", e + 1), 1'b0, 0, 0);
      else expect_cdb($sformatf("ovf_e%0d", e + 1), 1'b1, exp31_id[e],
                      (exp31_id[e] < 8) ? 'h100 + exp31_id[e] : 'h200 + exp31_id[e]);
      chk($sformatf("ovf_flag_e%0d", e + 1), 64'(overflow), 64'((e >= 7) ? 1 : 0));
    end

    // Asynchronous reset while results are buffered and one is on the bus.
    tick(1'b1, 5, 'h55, 1'b1, 6, 'h66); expect_cdb("mrst_e1", 1'b0, 0, 0);
    idle(); expect_cdb("mrst_e2", 1'b1, 5, 'h55);
    rst_in = 1'b0;
    #1;
    chk("mrst_async_req", 64'(cdb_req), 64'd0);
    chk("mrst_async_id", 64'(cdb_rob_id), 64'd0);
    chk("mrst_async_val", 64'(cdb_val), 64'd0);
    chk("mrst_async_ovf", 64'(overflow), 64'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    for (int e = 0; e < 3; e++) begin
      idle(); chk($sformatf("mrst_after_e%0d", e + 1), 64'(cdb_req), 64'd0);
    end

    // Clear with three buffered and a same-cycle push; last_grant must survive.
    tick(1'b1, 1, 'h1, 1'b1, 2, 'h2); expect_cdb("clr_e1", 1'b0, 0, 0);
    tick(1'b1, 3, 'h3, 1'b1, 4, 'h4); expect_cdb("clr_e2", 1'b1, 1, 'h1);
    clear = 1'b1;
    tick(1'b1, 5, 'h5, 1'b0, 0, 0); expect_cdb("clr_e3", 1'b0, 0, 0);
    chk("clr_astall", 64'(alu_stall), 64'd0);
    clear = 1'b0;
    idle(); expect_cdb("clr_e4", 1'b0, 0, 0);
    idle(); expect_cdb("clr_e5", 1'b0, 0, 0);
    tick(1'b1, 9, 'h99, 1'b1, 10, 'hAA); expect_cdb("clr_e6", 1'b0, 0, 0);
    idle(); expect_cdb("clr_e7", 1'b1, 10, 'hAA);
    idle(); expect_cdb("clr_e8", 1'b1, 9, 'h99);
    idle(); expect_cdb("clr_e9", 1'b0, 0, 0);

    // Pause three cycles with two buffered; ALU pulses during the pause are ignored.
    tick(1'b1, 1, 'h1, 1'b0, 0, 0); expect_cdb("pause_e1", 1'b0, 0, 0);
    tick(1'b1, 3, 'h3, 1'b1, 4, 'h4); expect_cdb("pause_e2", 1'b1, 1, 'h1);
    rdy_in = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick(1'b1, 7, 'h7, 1'b0, 0, 0);
      expect_cdb($sformatf("pause_hold_e%0d", e + 1), 1'b1, 1, 'h1);
    end
    rdy_in = 1'b1;
    idle(); expect_cdb("pause_e6", 1'b1, 4, 'h4);
    idle(); expect_cdb("pause_e7", 1'b1, 3, 'h3);
    idle(); expect_cdb("pause_e8", 1'b0, 0, 0);
    chk("final_ovf", 64'(overflow), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
